// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: shared ALU constants used by the writeback stage.
//   - ALU command codes (4 bits)
//   - Flag bit indices within the 3-bit flags word
//   - Writeback FSM state encoding (2 bits)
package alu_writeback_pkg;

    // ALU command codes
    localparam logic [3:0] CMD_PASSTHROUGH = 4'h0;  // load / move
    localparam logic [3:0] CMD_ADD         = 4'h1;
    localparam logic [3:0] CMD_SUB         = 4'h2;
    localparam logic [3:0] CMD_MULTIPLY    = 4'h3;
    localparam logic [3:0] CMD_AND         = 4'h4;
    localparam logic [3:0] CMD_OR          = 4'h5;
    localparam logic [3:0] CMD_XOR         = 4'h6;
    localparam logic [3:0] CMD_NOT         = 4'h7;

    // Flag bit positions shared by the ALU and the flags register
    localparam int unsigned ZERO_FLAG  = 0;
    localparam int unsigned CARRY_FLAG = 1;
    localparam int unsigned NEG_FLAG   = 2;

    // Writeback FSM states
    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WRITE_LO = 2'd1,
        WB_WRITE_HI = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// alu_writeback: stage after the ALU. Captures result/flags/destination on a
// valid/ready handshake, holds the architectural flags register and writes the
// result to the GP register file one byte per cycle (multiply: low byte to
// dest, high byte to dest+1 with wrap).
//
// Ports:
//   clk, reset (async, active-low)
//   alu_valid/alu_ready, alu_cmnd, alu_result, alu_flags, dest_reg : ALU side
//   wb_valid/wb_ready, wb_addr, wb_data                            : regfile side
//   flags_reg : architectural flags, busy : FSM not idle
//
// Build option: ALU_WB_FLAGS_PRESERVE_ON_PASS_EN - when defined, a PASSTHROUGH
// capture leaves flags_reg unchanged.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [3:0]            alu_cmnd,
    input  logic [15:0]           alu_result,
    input  logic [2:0]            alu_flags,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [7:0]            wb_data,
    output logic [2:0]            flags_reg,
    output logic                  busy
);

    localparam logic [REG_ADDR_W-1:0] ADDR_ONE = 1;

    wb_state_e             state_q, state_d;
    logic [3:0]            cmnd_q, cmnd_d;
    logic [15:0]           result_q, result_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [2:0]            flags_q, flags_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [7:0]            wb_data_q, wb_data_d;
    logic                  alu_ready_q, alu_ready_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cmnd_d      = cmnd_q;
        result_d    = result_q;
        dest_d      = dest_q;
        flags_d     = flags_q;
        wb_valid_d  = wb_valid_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        alu_ready_d = alu_ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            WB_IDLE: begin
                if (alu_valid) begin
                    state_d     = WB_WRITE_LO;
                    cmnd_d      = alu_cmnd;
                    result_d    = alu_result;
                    dest_d      = dest_reg;
`ifdef ALU_WB_FLAGS_PRESERVE_ON_PASS_EN
                    if (alu_cmnd != CMD_PASSTHROUGH) begin
                        flags_d = alu_flags;
                    end
`else
                    flags_d     = alu_flags;
`endif
                    // Outputs are registered, so the first write is set up here.
                    wb_valid_d  = 1'b1;
                    wb_addr_d   = dest_reg;
                    wb_data_d   = alu_result[7:0];
                    alu_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            WB_WRITE_LO: begin
                if (wb_ready) begin
                    if (cmnd_q == CMD_MULTIPLY) begin
                        state_d   = WB_WRITE_HI;
                        wb_addr_d = dest_q + ADDR_ONE;  // wraps at the top register
                        wb_data_d = result_q[15:8];
                    end else begin
                        state_d     = WB_IDLE;
                        wb_valid_d  = 1'b0;
                        alu_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end
            WB_WRITE_HI: begin
                if (wb_ready) begin
                    state_d     = WB_IDLE;
                    wb_valid_d  = 1'b0;
                    alu_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = WB_IDLE;
                wb_valid_d  = 1'b0;
                alu_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WB_IDLE;
            cmnd_q      <= '0;
            result_q    <= '0;
            dest_q      <= '0;
            flags_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            alu_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmnd_q      <= cmnd_d;
            result_q    <= result_d;
            dest_q      <= dest_d;
            flags_q     <= flags_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            alu_ready_q <= alu_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_ready = alu_ready_q;
    assign wb_valid  = wb_valid_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign flags_reg = flags_q;
    assign busy      = busy_q;

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the ALU. Captures the combinational ALU result, flags and destination register number with a valid/ready handshake.
- Holds the flags in the architectural flags register.
- Writes the result back to the GP register file one byte per cycle.
- Multiply's 16-bit product takes two write cycles: low byte to dest, high byte to dest+1. All other commands take one write cycle.

Parameters:
- REG_ADDR_W, 3, width of the GP register index; the register file has 2**REG_ADDR_W entries.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result, flags and command are valid this cycle.
- alu_ready  output  1  stage can accept a result; a capture occurs when alu_valid && alu_ready.
- alu_cmnd  input  4  command code that produced the result (ALU command codes).
- alu_result  input  16  ALU result.
- alu_flags  input  3  ALU flags (Zero, Carry, Negative, at the shared bit positions).
- dest_reg  input  REG_ADDR_W  destination GP register.
- wb_valid  output  1  register-file write request.
- wb_ready  input  1  register file accepts the write this cycle.
- wb_addr  output  REG_ADDR_W  write address.
- wb_data  output  8  write data.
- flags_reg  output  3  architectural flags register.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, wb_valid=0, wb_addr=0, wb_data=0, flags_reg=3'b000, busy=0, alu_ready=1; the captured result/dest/command registers are cleared to 0.
- Reset mid-operation aborts any pending write with no partial completion. After release, the first rising edge sees IDLE.
- FSM states:
  - IDLE: alu_ready=1, wb_valid=0.
  - WRITE_LO: wb_valid=1, wb_addr=dest, wb_data=result[7:0].
  - WRITE_HI: wb_valid=1, wb_addr=dest+1 (modulo 2**REG_ADDR_W, so the top register wraps to 0), wb_data=result[15:8].
- Transitions:
  - IDLE -> WRITE_LO on capture.
  - WRITE_LO with wb_ready=1 -> WRITE_HI if the captured command is multiply, else IDLE.
  - WRITE_HI with wb_ready=1 -> IDLE.
  - WRITE_LO or WRITE_HI with wb_ready=0: hold the state; wb_addr and wb_data stay stable.
- alu_ready is 1 only in IDLE; there is no accept during a write and no skid buffer.
- Latency: capture on edge N; wb_valid is high from cycle N+1. The earliest next capture is the edge after the final write is accepted (one result per 2 cycles, or 3 for multiply, with wb_ready held at 1).
- Capture also registers: cmnd, dest_reg, alu_result (all 16 bits), and alu_flags into flags_reg on the same edge.
- flags_reg changes only on capture (or reset). It is not modified by writeback and is stable while the register-file write is in progress.
- Unknown or default ALU command codes are captured and written as a single byte like any non-multiply command (the ALU drives 0 for them).
- wb_valid never deasserts until accepted. wb_ready asserted while wb_valid=0 is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALU_WB_FLAGS_PRESERVE_ON_PASS_EN.
- Defined: a capture whose command is PASSTHROUGH (load/move) leaves flags_reg unchanged. The register write is unaffected.
- Undefined: every capture, including PASSTHROUGH, loads alu_flags into flags_reg.

Decomposition:
- Shared constants header (existing constants file) holds:
  - ALU command codes (PASSTHROUGH, MULTIPLY, ...).
  - Flag bit indices ZERO_FLAG, CARRY_FLAG, NEG_FLAG.
  - New FSM state encodings WB_IDLE, WB_WRITE_LO, WB_WRITE_HI (2 bits).
- No sub-module is needed. The optional flags register could be factored as flags_register, but it stays inline: it is one 3-bit register with an enable.

Test Plan:
- ADD result 16'h0042, flags 3'b000, dest 3, wb_ready=1:
  - exactly one write: reg3=8'h42.
  - flags_reg=000 from N+1; alu_ready returns to 1 at N+2.
- MULTIPLY result 16'h1234, dest 7, REG_ADDR_W=3:
  - writes reg7=8'h34, then reg0=8'h12 (wrap).
  - busy high for 2 cycles; the zero flag is taken from alu_flags.
- Backpressure: MULTIPLY 16'hABCD, dest 2, wb_ready held 0 for 4 cycles then 1:
  - wb_addr=2 / wb_data=8'hCD stable throughout the stall.
  - then addr 3 / data 8'hAB; alu_valid held high is not captured until IDLE.
- Reset pulse (reset=0) asserted during WRITE_HI:
  - wb_valid drops immediately and asynchronously; flags_reg=000.
  - after release, a new ADD is captured normally.
- PASSTHROUGH with flags 3'b001 after a SUB that set flags 3'b110:
  - with ALU_WB_FLAGS_PRESERVE_ON_PASS_EN, flags_reg stays 110.
  - without the macro, flags_reg becomes 001.
- Back-to-back ADDs with alu_valid held high and wb_ready=1:
  - captures occur every 2 cycles; write order and data match input order.
